// File: rtl/niosii_system_sysid_checker_pkg.sv
// niosii_system_sysid_pkg: shared state encoding, sysid word addresses and default expected constants
package niosii_system_sysid_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RD_ID, ST_RD_TS, ST_DONE} state_t;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam logic [31:0] DEF_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'd1488912150;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/niosii_system_sysid_checker_if.sv
// niosii_system_sysid_checker_if: Avalon-MM read path between the checker and the sysid slave
interface niosii_system_sysid_checker_if;
  logic address;
  logic read;
  logic [31:0] readdata;
  logic waitrequest;
  modport master (output address, read, input readdata, waitrequest);
  modport slave (input address, read, output readdata, waitrequest);
endinterface

// File: rtl/niosii_system_sysid_checker_wait_timer.sv
// niosii_system_sysid_wait_timer: saturating count of stalled read cycles, expires at TIMEOUT_CYCLES
module niosii_system_sysid_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign expire = cnt == LIMIT;
  // holding at LIMIT keeps the counter from wrapping while the read stays stalled
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
endmodule

// File: rtl/niosii_system_sysid_checker.sv
// niosii_system_sysid_checker: reads sysid ID and timestamp, compares with expected values, flags pass/fail/timeout
module niosii_system_sysid_checker
  import niosii_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  niosii_system_sysid_checker_if.master avm,
  output logic                          busy,
  output logic                          done,
  output logic                          id_ok,
  output logic                          ts_ok,
  output logic                          timeout,
  output logic [31:0]                   id_value,
  output logic [31:0]                   ts_value
);
  state_t state;
  logic armed, reading, accept, launch, expire;
  assign reading = state == ST_RD_ID || state == ST_RD_TS;
  assign accept = reading && !avm.waitrequest;
  assign launch = armed || (start && (state == ST_IDLE || state == ST_DONE));
  niosii_system_sysid_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (launch || accept),
    .en     (reading && avm.waitrequest),
    .expire (expire)
  );
  // armed is set only by reset, so the auto launch fires once on the first edge after release
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      armed <= AUTO_START;
      avm.read <= 1'b0;
      avm.address <= SYSID_ADDR_ID;
      busy <= 1'b0;
      done <= 1'b0;
      id_ok <= 1'b0;
      ts_ok <= 1'b0;
      timeout <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      armed <= 1'b0;
      if (launch) begin
        state <= ST_RD_ID;
        avm.read <= 1'b1;
        avm.address <= SYSID_ADDR_ID;
        busy <= 1'b1;
        done <= 1'b0;
        id_ok <= 1'b0;
        ts_ok <= 1'b0;
        timeout <= 1'b0;
      end else if (accept && state == ST_RD_ID) begin
        state <= ST_RD_TS;
        avm.address <= SYSID_ADDR_TS;
        id_value <= avm.readdata;
      end else if (accept) begin
        state <= ST_DONE;
        avm.read <= 1'b0;
        ts_value <= avm.readdata;
        id_ok <= id_value == EXPECTED_ID;
        ts_ok <= avm.readdata == EXPECTED_TIMESTAMP;
        busy <= 1'b0;
        done <= 1'b1;
      end else if (reading && expire) begin
        state <= ST_DONE;
        avm.read <= 1'b0;
        timeout <= 1'b1;
        id_ok <= 1'b0;
        ts_ok <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// tb_niosii_system_sysid_checker: scoreboard bench, auto-start DUT a (timeout 4) and manual-start DUT b
module tb_niosii_system_sysid_checker;
  localparam logic [31:0] TS = 32'd1488912150;
  typedef struct {
    int          launch;
    int          lat;
    int          accepts;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_v;
    logic [31:0] ts_v;
  } exp_t;
  logic clock = 1'b0;
  logic rst_a_n = 1'b1, rst_b_n = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic [1:0] busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value [2];
  logic [31:0] ts_value [2];
  niosii_system_sysid_checker_if bus_a ();
  niosii_system_sysid_checker_if bus_b ();
  niosii_system_sysid_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b1)) dut_a (
    .clock(clock), .reset_n(rst_a_n), .start(start_a), .avm(bus_a),
    .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout(timeout[0]),
    .id_value(id_value[0]), .ts_value(ts_value[0])
  );
  niosii_system_sysid_checker #(.AUTO_START(1'b0)) dut_b (
    .clock(clock), .reset_n(rst_b_n), .start(start_b), .avm(bus_b),
    .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout(timeout[1]),
    .id_value(id_value[1]), .ts_value(ts_value[1])
  );
  always #5 clock = ~clock;
  int stall_n = 0, wcnt = 0;
  bit stuck_ts = 1'b0, stuck_b = 1'b0;
  logic [31:0] mem_id = 32'd0, mem_ts = TS;
  always @(posedge clock) wcnt <= (bus_a.read && bus_a.waitrequest) ? wcnt + 1 : 0;
  assign bus_a.waitrequest = bus_a.read && ((stuck_ts && bus_a.address) ? 1'b1 : (wcnt < stall_n));
  assign bus_a.readdata = bus_a.address ? mem_ts : mem_id;
  assign bus_b.waitrequest = bus_b.read && bus_b.address && stuck_b;
  assign bus_b.readdata = bus_b.address ? TS : 32'hA5;
  int n_chk = 0, n_err = 0, cyc = 0, accepts = 0;
  exp_t sb[$];
  exp_t cur;
  logic done_q = 1'b0, stall_q = 1'b0, addr_q = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_run(input int lat, input int acc, input logic iok, input logic tok,
                            input logic to, input logic [31:0] idv, input logic [31:0] tsv);
    exp_t e;
    e.launch = cyc + 1;
    e.lat = lat;
    e.accepts = acc;
    e.id_ok = iok;
    e.ts_ok = tok;
    e.timeout = to;
    e.id_v = idv;
    e.ts_v = tsv;
    sb.push_back(e);
  endtask
  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    check("sb_drain", sb.size(), 0);
    sb.delete();
    @(negedge clock);
  endtask
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (stall_q && !done[0]) begin
      check("hold_read", 32'(bus_a.read), 1);
      check("hold_addr", 32'(bus_a.address), 32'(addr_q));
    end
    stall_q = bus_a.read && bus_a.waitrequest;
    addr_q = bus_a.address;
    if (bus_a.read && !bus_a.waitrequest) accepts++;
    if (done[0] && !done_q) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        cur = sb.pop_front();
        check("latency", cyc - cur.launch, cur.lat);
        check("accepts", accepts, cur.accepts);
        check("id_ok", 32'(id_ok[0]), 32'(cur.id_ok));
        check("ts_ok", 32'(ts_ok[0]), 32'(cur.ts_ok));
        check("timeout", 32'(timeout[0]), 32'(cur.timeout));
        check("id_value", id_value[0], cur.id_v);
        check("ts_value", ts_value[0], cur.ts_v);
        check("read_at_done", 32'({bus_a.read, busy[0]}), 0);
      end
      accepts = 0;
    end
    done_q = done[0];
  end
  initial begin
    #1 rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_a_flags", 32'({busy[0], done[0], id_ok[0], ts_ok[0], timeout[0], bus_a.read, bus_a.address}), 0);
    check("rst_a_id", id_value[0], 0);
    check("rst_a_ts", ts_value[0], 0);
    expect_run(2, 2, 1, 1, 0, 0, TS);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    drain();
    mem_ts = TS + 1;
    expect_run(2, 2, 1, 0, 0, 0, TS + 1);
    pulse_a();
    check("relaunch_done_low", 32'({done[0], busy[0]}), 32'b01);
    drain();
    mem_ts = TS;
    stall_n = 3;
    expect_run(8, 2, 1, 1, 0, 0, TS);
    pulse_a();
    repeat (2) @(negedge clock);
    pulse_a();
    drain();
    repeat (12) @(negedge clock);
    check("ignored_start", 32'({done[0], busy[0]}), 32'b10);
    stall_n = 0;
    expect_run(2, 2, 1, 1, 0, 0, TS);
    pulse_a();
    check("restart_done_low", 32'(done[0]), 0);
    drain();
    stall_n = 4;
    expect_run(10, 2, 1, 1, 0, 0, TS);
    pulse_a();
    drain();
    stall_n = 0;
    stuck_ts = 1'b1;
    mem_ts = 32'h1234;
    expect_run(6, 1, 0, 0, 1, 0, TS);
    pulse_a();
    drain();
    stuck_ts = 1'b0;
    mem_ts = TS;
    check("b_no_auto", 32'({bus_b.read, busy[1], done[1]}), 0);
    stuck_b = 1'b1;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    repeat (3) @(negedge clock);
    check("b_stalled", 32'({bus_b.read, bus_b.address, busy[1]}), 32'b111);
    check("b_id_cap", id_value[1], 32'hA5);
    #2 rst_b_n = 1'b0;
    #1;
    check("b_rst_flags", 32'({busy[1], done[1], id_ok[1], ts_ok[1], timeout[1], bus_b.read, bus_b.address}), 0);
    check("b_rst_vals", id_value[1] | ts_value[1], 0);
    @(negedge clock);
    rst_b_n = 1'b1;
    stuck_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("b_idle_read", 32'(bus_b.read), 0);
    end
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("b_done", 32'({done[1], busy[1], id_ok[1], ts_ok[1], timeout[1]}), 32'b10010);
    check("b_ts", ts_value[1], TS);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
